// File: rtl/morra_cinese_param.sv
// Parametrised two-player Morra Cinese match FSMD: one move pair per clock, registered manche/match results.
// Define SCORE_OUT_EN to expose the registered scores and played count as PUNTI1/PUNTI2/NUM_MANCHE.
module morra_cinese_param #(
    parameter int N_MOVES    = 3,
    parameter int MOVE_W     = 2,
    parameter int MIN_MANCHE = 4,
    parameter int LEAD       = 2,
    localparam int CNT_W     = $clog2(MIN_MANCHE + 2**(2*MOVE_W)) + 1
) (
    input  logic              clk,
    input  logic              INIZIO,
    input  logic [MOVE_W-1:0] PRIMO,
    input  logic [MOVE_W-1:0] SECONDO,
`ifdef SCORE_OUT_EN
    output logic [CNT_W-1:0]  PUNTI1,
    output logic [CNT_W-1:0]  PUNTI2,
    output logic [CNT_W-1:0]  NUM_MANCHE,
`endif
    output logic [1:0]        MANCHE,
    output logic [1:0]        PARTITA
);

    localparam logic [0:0] PLAY = 1'b0;
    localparam logic [0:0] OVER = 1'b1;

    localparam logic [MOVE_W+1:0] NM = (MOVE_W+2)'(N_MOVES);

    logic [0:0]        state;
    logic [CNT_W-1:0]  score1, score2, played, max_manche;
    logic              last_valid;
    logic              last_id;      // 0 = player 1 won last, 1 = player 2
    logic [MOVE_W-1:0] last_move;

    logic              p1_ok, p2_ok, is_draw, p1_wins, repeat_hit, manche_ok;
    logic [MOVE_W+1:0] diff_raw, diff;
    logic [MOVE_W-1:0] win_move;
    logic [CNT_W-1:0]  s1_n, s2_n, pl_n, gap;
    logic [1:0]        result, match;

    // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
    always_comb begin
        p1_ok    = (PRIMO != '0)   && ({2'b00, PRIMO}   <= NM);
        p2_ok    = (SECONDO != '0) && ({2'b00, SECONDO} <= NM);

        // Both codes lie in 1..N_MOVES when used, so one conditional subtract yields the modulo.
        diff_raw = {2'b00, PRIMO} + NM - {2'b00, SECONDO};
        diff     = (diff_raw >= NM) ? diff_raw - NM : diff_raw;
        is_draw  = (diff == '0);
        p1_wins  = diff[0];
        win_move = p1_wins ? PRIMO : SECONDO;

        repeat_hit = last_valid && !is_draw && (last_id == !p1_wins) && (win_move == last_move);
        manche_ok  = p1_ok && p2_ok && !repeat_hit;
        result     = is_draw ? 2'b11 : (p1_wins ? 2'b01 : 2'b10);

        s1_n = score1 + {{(CNT_W-1){1'b0}}, p1_wins};
        s2_n = score2 + {{(CNT_W-1){1'b0}}, !is_draw && !p1_wins};
        pl_n = played + CNT_W'(1);
        gap  = (s1_n >= s2_n) ? s1_n - s2_n : s2_n - s1_n;

        match = 2'b00;
        if (((pl_n >= CNT_W'(MIN_MANCHE)) && (gap >= CNT_W'(LEAD))) || (pl_n == max_manche)) begin
            if (s1_n > s2_n)      match = 2'b01;
            else if (s2_n > s1_n) match = 2'b10;
            else                  match = 2'b11;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (INIZIO) begin
            state      <= PLAY;
            MANCHE     <= 2'b00;
            PARTITA    <= 2'b00;
            score1     <= '0;
            score2     <= '0;
            played     <= '0;
            max_manche <= CNT_W'(MIN_MANCHE) + CNT_W'({PRIMO, SECONDO});
            last_valid <= 1'b0;
            last_id    <= 1'b0;
            last_move  <= '0;
        end else if (state == PLAY) begin
            if (manche_ok) begin
                MANCHE     <= result;
                PARTITA    <= match;
                score1     <= s1_n;
                score2     <= s2_n;
                played     <= pl_n;
                last_valid <= !is_draw;
                last_id    <= !p1_wins;
                last_move  <= win_move;
                if (match != 2'b00) state <= OVER;
            end else begin
                MANCHE <= 2'b00;
            end
        end else begin
            MANCHE <= 2'b00;
        end
    end

`ifdef SCORE_OUT_EN
    assign PUNTI1     = score1;
    assign PUNTI2     = score2;
    assign NUM_MANCHE = played;
`endif

endmodule
